cache_ri_line_fill: RTL and testbench

- Line replacement engine for the cache data store.
- On a miss it optionally writes back the victim line, word by word, from the data RAM to main memory, then refills the same way/index from memory.
- It drives the replacement-side (ri_*) port set of the cache data block and owns its select line for the whole operation.
- Sits between the cache miss controller (request side) and the memory bus (single-word, Avalon-style).

---
 rtl/cache_ri_line_fill.sv | 202 ++++++++++++++++++++
 tb/tb_cache_ri_line_fill.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ri_line_fill.sv
// Line replacement engine for the cache data store.
// On a miss it optionally copies the victim line word by word from the data
// RAM out to main memory, then refills the same way/index from memory.
// It owns the replacement-side (ri_*) port of the data store for the whole
// operation and talks to a single-word Avalon-style memory bus.
module cache_ri_line_fill #(
    parameter int ADDR_WIDTH = 8,   // data RAM word address: {index, wordOffset}
    parameter int WORD_BITS  = 2    // log2(words per line), must be < ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,

    // Request side (miss controller)
    input  logic                             req_valid,
    input  logic                             req_writeback,
    input  logic [1:0]                       req_ch,
    input  logic [ADDR_WIDTH-WORD_BITS-1:0]  req_index,
    input  logic [31:0]                      req_wbAddr,
    input  logic [31:0]                      req_fillAddr,
    output logic                             busy,
    output logic                             done,

    // Replacement-side data store port
    output logic                             ri_sel,
    output logic [1:0]                       ri_rwChannel,
    output logic [ADDR_WIDTH-1:0]            ri_readAddress,
    input  logic [31:0]                      ri_readData,
    output logic [ADDR_WIDTH-1:0]            ri_writeAddress,
    output logic [3:0]                       ri_writeByteEnable,
    output logic                             ri_writeEnable,
    output logic [31:0]                      ri_writeData,

    // Memory bus
    output logic [31:0]                      mem_address,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [31:0]                      mem_writeData,
    input  logic                             mem_waitRequest,
    input  logic [31:0]                      mem_readData,
    input  logic                             mem_readDataValid
);

    localparam int IDX_W = ADDR_WIDTH - WORD_BITS;

    // Byte-offset bits inside one line; cleared from the request addresses so
    // any offset the miss controller passes in is ignored.
    localparam logic [31:0] LINE_MASK = 32'((64'd1 << (WORD_BITS + 2)) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_ADDR,
        S_WB_DATA,
        S_WB_WR,
        S_RF_REQ,
        S_RF_WAIT,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [WORD_BITS-1:0] wordcnt_q;
    logic [WORD_BITS-1:0] wordcnt_d;
    logic [1:0]           ch_q;
    logic [IDX_W-1:0]     index_q;
    logic [31:0]          wbaddr_q;
    logic [31:0]          filladdr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [31:0]          mem_wdata_q;

    logic                 last_word;
    logic                 in_wb_phase;
    logic [31:0]          line_addr;
    logic                 fill_strobe;

    // Word counter helpers shared by the writeback and refill loops.
    always_comb begin
        wordcnt_d = wordcnt_q + WORD_BITS'(1);
        last_word = &wordcnt_q;
    end

    // Main control FSM; all handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wordcnt_q   <= '0;
            ch_q        <= '0;
            index_q     <= '0;
            wbaddr_q    <= '0;
            filladdr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ch_q       <= req_ch;
                        index_q    <= req_index;
                        wbaddr_q   <= req_wbAddr;
                        filladdr_q <= req_fillAddr;
                        wordcnt_q  <= '0;
                        busy_q     <= 1'b1;
                        if (req_writeback) begin
                            state_q <= S_WB_ADDR;
                        end else begin
                            state_q    <= S_RF_REQ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end

                // RAM address is presented this cycle; data returns next cycle.
                S_WB_ADDR: begin
                    state_q <= S_WB_DATA;
                end

                S_WB_DATA: begin
                    mem_wdata_q <= ri_readData;
                    mem_write_q <= 1'b1;
                    state_q     <= S_WB_WR;
                end

                // Hold the write request (address and data) until accepted.
                S_WB_WR: begin
                    if (!mem_waitRequest) begin
                        mem_write_q <= 1'b0;
                        wordcnt_q   <= wordcnt_d;
                        if (last_word) begin
                            state_q    <= S_RF_REQ;
                            mem_read_q <= 1'b1;
                        end else begin
                            state_q <= S_WB_ADDR;
                        end
                    end
                end

                S_RF_REQ: begin
                    if (!mem_waitRequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= S_RF_WAIT;
                    end
                end

                // Only one read is ever outstanding, so the next return strobe
                // belongs to the current word.
                S_RF_WAIT: begin
                    if (mem_readDataValid) begin
                        wordcnt_q <= wordcnt_d;
                        if (last_word) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RF_REQ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory address mux: victim line during writeback, fill line otherwise.
    always_comb begin
        in_wb_phase = (state_q == S_WB_ADDR) || (state_q == S_WB_DATA) ||
                      (state_q == S_WB_WR);
        line_addr   = in_wb_phase ? wbaddr_q : filladdr_q;
        mem_address = (line_addr & ~LINE_MASK) | (32'(wordcnt_q) << 2);
    end

    // Refill writes go straight from the bus return into the RAM.
    always_comb begin
        fill_strobe        = (state_q == S_RF_WAIT) && mem_readDataValid;
        ri_writeEnable     = fill_strobe;
        ri_writeByteEnable = fill_strobe ? 4'hF : 4'h0;
        ri_writeData       = mem_readData;
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign ri_sel          = busy_q;
    assign ri_rwChannel    = ch_q;
    assign ri_readAddress  = {index_q, wordcnt_q};
    assign ri_writeAddress = {index_q, wordcnt_q};
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_writeData   = mem_wdata_q;

endmodule

// File: tb/tb_cache_ri_line_fill.sv
// Bench for cache_ri_line_fill: bench-owned data RAM and memory slave, an
// expectation model built from the line-address rules, and a per-cycle compare.
module tb_cache_ri_line_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_writeback = 1'b0;
    logic [1:0]  req_ch = '0;
    logic [5:0]  req_index = '0;
    logic [31:0] req_wbAddr = '0;
    logic [31:0] req_fillAddr = '0;
    logic        busy, done, ri_sel;
    logic [1:0]  ri_rwChannel;
    logic [7:0]  ri_readAddress, ri_writeAddress;
    logic [31:0] ri_readData;
    logic [3:0]  ri_writeByteEnable;
    logic        ri_writeEnable;
    logic [31:0] ri_writeData;
    logic [31:0] mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writeData;
    logic        mem_waitRequest = 1'b0;
    logic [31:0] mem_readData = '0;
    logic        mem_readDataValid = 1'b0;

    always #5 clk = ~clk;

    cache_ri_line_fill #(.ADDR_WIDTH(8), .WORD_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_writeback(req_writeback), .req_ch(req_ch),
        .req_index(req_index), .req_wbAddr(req_wbAddr), .req_fillAddr(req_fillAddr),
        .busy(busy), .done(done),
        .ri_sel(ri_sel), .ri_rwChannel(ri_rwChannel), .ri_readAddress(ri_readAddress),
        .ri_readData(ri_readData), .ri_writeAddress(ri_writeAddress),
        .ri_writeByteEnable(ri_writeByteEnable), .ri_writeEnable(ri_writeEnable),
        .ri_writeData(ri_writeData),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writeData(mem_writeData), .mem_waitRequest(mem_waitRequest),
        .mem_readData(mem_readData), .mem_readDataValid(mem_readDataValid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred where none was required", name);
    endtask

    // Main memory content: a distinct word per byte address, 0xA0..0xA3 for
    // the line at 0x1000_0040.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'h1000_0040) & ~32'hF;
        return 32'hA0 + {30'b0, a[3:2]} + (off << 4);
    endfunction

    // ---------------- bench-owned data RAM (registered read) ----------------
    logic [31:0] ram [4][256];
    logic        pre_we = 1'b0;
    logic [1:0]  pre_ch = '0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_ch][pre_addr] <= pre_data;
        else if (ri_sel && ri_writeEnable)
            ram[ri_rwChannel][ri_writeAddress] <= ri_writeData;
        ri_readData <= ram[ri_rwChannel][ri_readAddress];
    end

    task automatic preload(input logic [1:0] ch, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_ch = ch; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // ---------------- memory slave ----------------
    int          wr_idx = 0, rd_idx = 0;
    int          stall_wr = -1, stall_rd = -1, wr_left = 0, rd_left = 0;
    bit          inject_valid = 1'b0;
    bit          rd_pend = 1'b0;
    logic [31:0] pend_addr = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                rd_pend = 1'b0;
                mem_readDataValid = 1'b0;
                mem_waitRequest = 1'b0;
            end else begin
                #1;
                mem_readDataValid = rd_pend;
                mem_readData = rd_pend ? mem_word(pend_addr) : 32'h0;
                rd_pend = 1'b0;
                if (inject_valid && mem_write && !mem_readDataValid) begin
                    mem_readDataValid = 1'b1;
                    mem_readData = 32'hDEAD_BEEF;
                    inject_valid = 1'b0;
                end
                mem_waitRequest = 1'b0;
                if (mem_write && wr_idx == stall_wr && wr_left > 0) begin
                    mem_waitRequest = 1'b1;
                    wr_left--;
                end else if (mem_read && rd_idx == stall_rd && rd_left > 0) begin
                    mem_waitRequest = 1'b1;
                    rd_left--;
                end
                if (mem_read && !mem_waitRequest) begin
                    rd_pend = 1'b1;
                    pend_addr = mem_address;
                    rd_idx++;
                end
                if (mem_write && !mem_waitRequest) wr_idx++;
            end
        end
    end

    // ---------------- expectation model ----------------
    logic [31:0] q_wr_addr[$], q_wr_data[$], q_rd_addr[$], q_ram_data[$];
    logic [7:0]  q_ram_addr[$];
    logic [31:0] log_wr_addr[$], log_wr_data[$];
    logic [1:0]  exp_ch = '0;
    int          exp_lat = 0, req_cycle = 0, last_lat = 0;
    int          ram_wr_cnt = 0, done_cnt = 0, sel_low_cnt = 0;

    task automatic flush_model();
        q_wr_addr.delete(); q_wr_data.delete(); q_rd_addr.delete();
        q_ram_data.delete(); q_ram_addr.delete();
    endtask

    // Build the full expected transaction list, then drive the request for
    // one sampling edge.  Caller positions this inside the request cycle.
    task automatic issue(input logic [1:0] ch, input logic [5:0] idx, input bit wb,
                         input logic [31:0] wba, input logic [31:0] fa, input int extra);
        logic [31:0] bw, bf;
        logic [7:0]  ra;
        bw = wba & ~32'hF;
        bf = fa & ~32'hF;
        for (int k = 0; k < 4; k++) begin
            ra = {idx, 2'(k)};
            if (wb) begin
                q_wr_addr.push_back(bw + 32'(4 * k));
                q_wr_data.push_back(ram[ch][ra]);
            end
            q_rd_addr.push_back(bf + 32'(4 * k));
            q_ram_addr.push_back(ra);
            q_ram_data.push_back(mem_word(bf + 32'(4 * k)));
        end
        exp_ch  = ch;
        exp_lat = 10 + (wb ? 12 : 0) + extra;
        wr_idx  = 0;
        rd_idx  = 0;
        log_wr_addr.delete();
        log_wr_data.delete();
        req_ch = ch; req_index = idx; req_writeback = wb;
        req_wbAddr = wba; req_fillAddr = fa;
        req_valid = 1'b1;
        req_cycle = cycle;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("issue: ch=%0d idx=0x%02h wb=%0d wbAddr=0x%08h fillAddr=0x%08h", ch, idx, wb, wba, fa);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            fail_now({name, "_timeout"});
        end else begin
            last_lat = cycle - req_cycle + 1;
            check({name, "_latency"}, 32'(last_lat), 32'(exp_lat));
            $display("done: %s latency=%0d cycles", name, last_lat);
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_queues_empty"},
              32'(q_wr_addr.size() + q_rd_addr.size() + q_ram_data.size()), 32'd0);
    endtask

    // ---------------- per-cycle compare ----------------
    bit          hold_w = 1'b0, hold_r = 1'b0;
    logic [31:0] hold_addr = '0, hold_wdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_w = 1'b0;
                hold_r = 1'b0;
            end else begin
                check("sel_eq_busy", 32'(ri_sel), 32'(busy));
                check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
                check("byte_enable", 32'(ri_writeByteEnable), ri_writeEnable ? 32'hF : 32'h0);
                if (!ri_sel) sel_low_cnt++;
                if (hold_w) begin
                    check("wr_hold_req", 32'(mem_write), 32'd1);
                    check("wr_hold_addr", mem_address, hold_addr);
                    check("wr_hold_data", mem_writeData, hold_wdata);
                end
                if (hold_r) begin
                    check("rd_hold_req", 32'(mem_read), 32'd1);
                    check("rd_hold_addr", mem_address, hold_addr);
                end
                if (mem_write && !mem_waitRequest) begin
                    log_wr_addr.push_back(mem_address);
                    log_wr_data.push_back(mem_writeData);
                    $display("mem write: addr=0x%08h data=0x%08h", mem_address, mem_writeData);
                    if (q_wr_addr.size() == 0) fail_now("unexpected_mem_write");
                    else begin
                        check("wr_addr", mem_address, q_wr_addr.pop_front());
                        check("wr_data", mem_writeData, q_wr_data.pop_front());
                    end
                end
                if (mem_read && !mem_waitRequest) begin
                    $display("mem read: addr=0x%08h", mem_address);
                    if (q_rd_addr.size() == 0) fail_now("unexpected_mem_read");
                    else check("rd_addr", mem_address, q_rd_addr.pop_front());
                end
                if (ri_writeEnable) begin
                    ram_wr_cnt++;
                    $display("ram write: ch=%0d addr=0x%02h data=0x%08h", ri_rwChannel, ri_writeAddress, ri_writeData);
                    check("ram_we_needs_valid", 32'(mem_readDataValid), 32'd1);
                    if (q_ram_data.size() == 0) fail_now("unexpected_ram_write");
                    else begin
                        check("ram_ch", 32'(ri_rwChannel), 32'(exp_ch));
                        check("ram_addr", 32'(ri_writeAddress), 32'(q_ram_addr.pop_front()));
                        check("ram_data", ri_writeData, q_ram_data.pop_front());
                    end
                end
                if (done) done_cnt++;
                hold_w     = mem_write && mem_waitRequest;
                hold_r     = mem_read && mem_waitRequest;
                hold_addr  = mem_address;
                hold_wdata = mem_writeData;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base, d0, s0;
        bit hit;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(ri_sel), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_ram_we", 32'(ri_writeEnable), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_ram_raddr", 32'(ri_readAddress), 32'd0);
        check("rst_mem_wdata", mem_writeData, 32'd0);
        rst_n = 1'b1;

        // Clean refill
        @(negedge clk);
        issue(2'd2, 6'h05, 1'b0, 32'h0, 32'h1000_0040, 0);
        wait_done("clean");
        check("clean_lat_literal", 32'(last_lat), 32'd10);
        finish_op("clean");
        check("clean_ram14", ram[2][8'h14], 32'h0000_00A0);
        check("clean_ram15", ram[2][8'h15], 32'h0000_00A1);
        check("clean_ram16", ram[2][8'h16], 32'h0000_00A2);
        check("clean_ram17", ram[2][8'h17], 32'h0000_00A3);

        // Dirty replace
        preload(2'd1, 8'h0C, 32'h11);
        preload(2'd1, 8'h0D, 32'h22);
        preload(2'd1, 8'h0E, 32'h33);
        preload(2'd1, 8'h0F, 32'h44);
        @(negedge clk);
        issue(2'd1, 6'h03, 1'b1, 32'h2000_0030, 32'h1000_0080, 0);
        wait_done("dirty");
        check("dirty_lat_literal", 32'(last_lat), 32'd22);
        finish_op("dirty");
        check("dirty_wr0_addr", log_wr_addr[0], 32'h2000_0030);
        check("dirty_wr0_data", log_wr_data[0], 32'h11);
        check("dirty_wr3_addr", log_wr_addr[3], 32'h2000_003C);
        check("dirty_wr3_data", log_wr_data[3], 32'h44);
        check("dirty_ram0C", ram[1][8'h0C], 32'h0000_04A0);

        // Backpressure on the second write and third read
        preload(2'd0, 8'h40, 32'h55);
        preload(2'd0, 8'h41, 32'h66);
        preload(2'd0, 8'h42, 32'h77);
        preload(2'd0, 8'h43, 32'h88);
        stall_wr = 1; stall_rd = 2; wr_left = 3; rd_left = 3;
        @(negedge clk);
        issue(2'd0, 6'h10, 1'b1, 32'h2000_0100, 32'h1000_00C0, 6);
        wait_done("backpressure");
        finish_op("backpressure");
        stall_wr = -1; stall_rd = -1;
        check("bp_wr1_data", log_wr_data[1], 32'h66);

        // Spurious req_valid while busy and readDataValid during a write
        preload(2'd3, 8'h80, 32'hC0FF_EE00);
        preload(2'd3, 8'h81, 32'hC0FF_EE01);
        preload(2'd3, 8'h82, 32'hC0FF_EE02);
        preload(2'd3, 8'h83, 32'hC0FF_EE03);
        inject_valid = 1'b1;
        @(negedge clk);
        issue(2'd3, 6'h20, 1'b1, 32'h2000_0037, 32'h1000_0108, 0);
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_ch = 2'd0; req_index = 6'h3F; req_writeback = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        wait_done("spurious");
        finish_op("spurious");
        check("spur_wr0_addr", log_wr_addr[0], 32'h2000_0030);
        check("spur_inject_used", 32'(inject_valid), 32'd0);

        // Reset in the middle of a refill
        base = ram_wr_cnt;
        @(negedge clk);
        issue(2'd1, 6'h08, 1'b0, 32'h0, 32'h1000_0100, 0);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (ram_wr_cnt >= base + 2) hit = 1'b1;
        end
        if (!hit) fail_now("abort_setup_timeout");
        d0 = done_cnt;
        @(posedge clk);
        #3;
        check("abort_pre_read", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(ri_sel), 32'd0);
        check("abort_mem_read", 32'(mem_read), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        flush_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_word1", ram[1][8'h21], 32'h0000_0CA1);
        issue(2'd1, 6'h08, 1'b0, 32'h0, 32'h1000_0100, 0);
        wait_done("after_abort");
        finish_op("after_abort");
        check("after_abort_w3", ram[1][8'h23], 32'h0000_0CA3);

        // Back-to-back requests
        @(negedge clk);
        issue(2'd0, 6'h30, 1'b0, 32'h0, 32'h1000_0200, 0);
        wait_done("b2b_first");
        s0 = sel_low_cnt;
        @(posedge clk);
        #1;
        issue(2'd2, 6'h31, 1'b0, 32'h0, 32'h1000_0240, 0);
        @(negedge clk);
        check("b2b_sel_gap", 32'(sel_low_cnt - s0), 32'd1);
        wait_done("b2b_second");
        finish_op("b2b_second");
        check("b2b_ram_c4", ram[2][8'hC4], mem_word(32'h1000_0240));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
